// File: rtl/mac_sequencer_pkg.sv
// Shared widths, limits and FSM encoding for the MAC sequencer.
package mac_sequencer_pkg;

  localparam int DATA_W = 4;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int MAX_N  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    ACCUM = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// Operand stream and result handshake bundle between fetch, MAC and write-back.
interface mac_sequencer_if;
  import mac_sequencer_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;
  logic              busy;

  modport master (
    output start, a_in, b_in, in_valid, result_ready,
    input  in_ready, result, result_valid, busy
  );

  modport slave (
    input  start, a_in, b_in, in_valid, result_ready,
    output in_ready, result, result_valid, busy
  );

endinterface

// File: rtl/mac_sequencer_mult_4x4.sv
// Unsigned 4x4 -> 8 array multiplier: AND-gate partial products summed by an adder chain.
module mult_4x4
  import mac_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [PROD_W-1:0] o_p
);

  logic [PROD_W-1:0] w_pp  [DATA_W];
  logic [PROD_W-1:0] w_sum [DATA_W+1];

  assign w_sum[0] = '0;

  // Each row is a gated by one bit of b, shifted into place and added to the running sum.
  for (genvar g = 0; g < DATA_W; g++) begin : g_row
    assign w_pp[g]    = PROD_W'(i_a & {DATA_W{i_b[g]}}) << g;
    assign w_sum[g+1] = w_sum[g] + w_pp[g];
  end

  assign o_p = w_sum[DATA_W];

endmodule

// File: rtl/mac_sequencer.sv
// Sequenced multiply-accumulate: clears, accumulates N operand products, then
// holds the dot product on a valid/ready output until the consumer takes it.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_sequencer_if.slave   bus
);

  localparam int               CNT_W     = $clog2(MAX_N);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  state_e             r_state;
  state_e             w_nextState;
  logic [CNT_W-1:0]   r_beatCnt;
  logic [ACC_W-1:0]   r_accum;
  logic [PROD_W-1:0]  w_prod;
  logic               w_clear;
  logic               w_inReady;
  logic               w_resultValid;
  logic               w_busy;
  logic               w_ld;

  mult_4x4 u_mult (
    .i_a (bus.a_in),
    .i_b (bus.b_in),
    .o_p (w_prod)
  );

  // A beat is an accepted pair; in_ready is only ever high in ACCUM.
  assign w_ld = w_inReady & bus.in_valid;

  // State register; reset drops any partial run back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state decode; start only counts in IDLE, so a start during the DONE handshake is lost.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = CLEAR;
      CLEAR:   w_nextState = ACCUM;
      ACCUM:   if (w_ld && (r_beatCnt == LAST_BEAT)) w_nextState = DONE;
      DONE:    if (bus.result_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode purely from the registered state so no input reaches an output combinationally.
  always_comb begin
    w_clear       = 1'b0;
    w_inReady     = 1'b0;
    w_resultValid = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      IDLE:    w_busy        = 1'b0;
      CLEAR:   w_clear       = 1'b1;
      ACCUM:   w_inReady     = 1'b1;
      DONE:    w_resultValid = 1'b1;
      default: w_busy        = 1'b0;
    endcase
  end

  // Beat counter: zeroed in CLEAR, advanced on each accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_beatCnt <= '0;
    else if (w_clear) r_beatCnt <= '0;
    else if (w_ld)    r_beatCnt <= r_beatCnt + 1'b1;
  end

  // Accumulator with clear > load > hold; it keeps its value after DONE until the next CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_accum <= '0;
    else if (w_clear) r_accum <= '0;
    else if (w_ld)    r_accum <= r_accum + {2'b00, w_prod};
  end

  assign bus.in_ready     = w_inReady;
  assign bus.result_valid = w_resultValid;
  assign bus.busy         = w_busy;
  assign bus.result       = r_accum;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: one N=4 instance and one N=1 instance
// share the operand/ready stimulus but each has its own start and result queue.
module tb_mac_sequencer;
  import mac_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       startA = 1'b0;
  logic       startB = 1'b0;
  logic       inValid = 1'b0;
  logic       resultReady = 1'b1;
  logic [3:0] opA = '0;
  logic [3:0] opB = '0;

  int cyc = 0;
  int vectorCount = 0;
  int missCount = 0;
  int expQA[$];
  int expQB[$];
  int expA;
  int expB;

  mac_sequencer_if ifA ();
  mac_sequencer_if ifB ();

  assign ifA.start        = startA;
  assign ifA.a_in         = opA;
  assign ifA.b_in         = opB;
  assign ifA.in_valid     = inValid;
  assign ifA.result_ready = resultReady;
  assign ifB.start        = startB;
  assign ifB.a_in         = opA;
  assign ifB.b_in         = opB;
  assign ifB.in_valid     = inValid;
  assign ifB.result_ready = resultReady;

  mac_sequencer #(.N(4)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  mac_sequencer #(.N(1)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  // Cycle count advances on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic inReadyOf(input int sel);
    return (sel != 0) ? ifB.in_ready : ifA.in_ready;
  endfunction

  function automatic logic resultValidOf(input int sel);
    return (sel != 0) ? ifB.result_valid : ifA.result_valid;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel != 0) ? ifB.busy : ifA.busy;
  endfunction

  function automatic int resultOf(input int sel);
    return (sel != 0) ? int'(ifB.result) : int'(ifA.result);
  endfunction

  // Monitor for the N=4 instance: compares each taken result against the queue head.
  always @(negedge clk) begin
    if (rst_n && ifA.result_valid && ifA.result_ready) begin
      if (expQA.size() == 0) begin
        checkOutput("A unexpected result", int'(ifA.result), -1);
      end else begin
        expA = expQA.pop_front();
        checkOutput("A result", int'(ifA.result), expA);
      end
    end
  end

  // Monitor for the N=1 instance.
  always @(negedge clk) begin
    if (rst_n && ifB.result_valid && ifB.result_ready) begin
      if (expQB.size() == 0) begin
        checkOutput("B unexpected result", int'(ifB.result), -1);
      end else begin
        expB = expQB.pop_front();
        checkOutput("B result", int'(ifB.result), expB);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic pulseStart(input int sel, output int startCyc);
    if (sel != 0) startB = 1'b1;
    else          startA = 1'b1;
    startCyc = cyc;
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic feedPair(input int sel, input int a, input int b);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    opA = 4'(a);
    opB = 4'(b);
    inValid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      rdy = inReadyOf(sel);
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("pair accept timeout", 0, 1);
  endtask

  task automatic applyStimulus(input int sel, input int n, input int pa[4], input int pb[4],
                               input int gap, input int expSum, input int expLat,
                               input bit hold, input string tag);
    int startCyc;
    if (sel != 0) expQB.push_back(expSum);
    else          expQA.push_back(expSum);
    opA = 4'(pa[0]);
    opB = 4'(pb[0]);
    inValid = (gap == 0);
    pulseStart(sel, startCyc);
    for (int i = 0; i < n; i++) begin
      feedPair(sel, pa[i], pb[i]);
      if (gap > 0 && i < n - 1) begin
        inValid = 1'b0;
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    inValid = 1'b0;
    checkOutput({tag, " result_valid"}, int'(resultValidOf(sel)), 1);
    if (expLat > 0) checkOutput({tag, " latency"}, cyc - startCyc, expLat);
    if (!hold) begin
      for (int t = 0; t < 20 && busyOf(sel); t++) begin
        @(posedge clk); #1;
      end
      checkOutput({tag, " busy after handshake"}, int'(busyOf(sel)), 0);
    end
  endtask

  initial begin
    $display("[TB] mac_sequencer bench starting");

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", int'(ifA.in_ready), 0);
    checkOutput("reset result_valid", int'(ifA.result_valid), 0);
    checkOutput("reset result", int'(ifA.result), 0);
    checkOutput("reset busy", int'(ifA.busy), 0);
    checkOutput("reset B busy", int'(ifB.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-ACCUM after two beats discards the partial sum
    opA = 4'd5; opB = 4'd5; inValid = 1'b1;
    begin
      int sc;
      pulseStart(0, sc);
    end
    feedPair(0, 5, 5);
    feedPair(0, 5, 5);
    checkOutput("mid-run accum", int'(ifA.result), 50);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset in_ready", int'(ifA.in_ready), 0);
    checkOutput("async reset result_valid", int'(ifA.result_valid), 0);
    checkOutput("async reset result", int'(ifA.result), 0);
    checkOutput("async reset busy", int'(ifA.busy), 0);
    inValid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 4, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 4, 6, 1'b0, "post-reset");

    // Maximum sum with in_valid held high
    applyStimulus(0, 4, '{15, 15, 15, 15}, '{15, 15, 15, 15}, 0, 900, 6, 1'b0, "max sum");

    // Two-cycle gaps between beats
    applyStimulus(0, 4, '{3, 0, 7, 2}, '{2, 9, 1, 5}, 2, 23, 0, 1'b0, "gaps");

    // Output backpressure with stray start/in_valid while DONE
    resultReady = 1'b0;
    applyStimulus(0, 4, '{2, 2, 2, 2}, '{3, 3, 3, 3}, 0, 24, 6, 1'b1, "backpressure");
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold result", int'(ifA.result), 24);
      checkOutput("hold result_valid", int'(ifA.result_valid), 1);
      checkOutput("hold in_ready", int'(ifA.in_ready), 0);
      startA = (i == 1);
      inValid = (i == 2);
      opA = 4'd15;
      opB = 4'd15;
      @(posedge clk); #1;
    end
    startA = 1'b0;
    inValid = 1'b0;
    checkOutput("hold result final", int'(ifA.result), 24);
    resultReady = 1'b1;
    startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    checkOutput("handshake busy", int'(ifA.busy), 0);
    checkOutput("handshake result_valid", int'(ifA.result_valid), 0);
    @(posedge clk); #1;
    checkOutput("start at handshake ignored", int'(ifA.busy), 0);
    checkOutput("accum kept in IDLE", int'(ifA.result), 24);

    // Back-to-back runs with no carryover
    applyStimulus(0, 4, '{4, 4, 4, 4}, '{4, 4, 4, 4}, 0, 64, 6, 1'b0, "run1");
    applyStimulus(0, 4, '{1, 1, 1, 1}, '{2, 2, 2, 2}, 0, 8, 6, 1'b0, "run2");

    // Short length on the N=1 instance
    applyStimulus(1, 1, '{9, 0, 0, 0}, '{6, 0, 0, 0}, 0, 54, 3, 1'b0, "N=1");
    checkOutput("A idle during B run", int'(ifA.busy), 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("A scoreboard drain", expQA.size(), 0);
    checkOutput("B scoreboard drain", expQB.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
